uart_frame_decoder: RTL and testbench



---
 rtl/uart_frame_decoder_if.sv | 27 ++
 rtl/uart_frame_decoder.sv | 171 +++++++++++++++++
 tb/tb_uart_frame_decoder.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_decoder_if.sv
// Byte-strobe input and decoded-frame output bundle for uart_frame_decoder.
// slave = decoder side, master = receiver/consumer side.
interface uart_frame_decoder_if #(
  parameter int MAX_BYTES = 16
);
  logic                   i_Rx_DV;
  logic [7:0]             i_Rx_Byte;
  logic                   o_Frame_Valid;
  logic [7:0]             o_Frame_Cmd;
  logic [7:0]             o_Frame_Len;
  logic [8*MAX_BYTES-1:0] o_Frame_Data;
  logic                   o_Frame_Err;
  logic [1:0]             o_Err_Code;
  logic                   o_Busy;

  modport slave (
    input  i_Rx_DV, i_Rx_Byte,
    output o_Frame_Valid, o_Frame_Cmd, o_Frame_Len, o_Frame_Data,
           o_Frame_Err, o_Err_Code, o_Busy
  );

  modport master (
    output i_Rx_DV, i_Rx_Byte,
    input  o_Frame_Valid, o_Frame_Cmd, o_Frame_Len, o_Frame_Data,
           o_Frame_Err, o_Err_Code, o_Busy
  );
endinterface

// File: rtl/uart_frame_decoder.sv
// Parses SYNC, CMD, LEN, payload[LEN], CHECK frames from a UART byte stream.
// Define UART_FRAME_CRC8_EN to use CRC-8 (poly 0x07) as the check value instead of plain XOR.
module uart_frame_decoder #(
  parameter int         MAX_BYTES    = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 1280
) (
  input logic                 i_Clock,
  input logic                 i_n_Reset,
  uart_frame_decoder_if.slave io_Bus
);

  localparam int                  LP_DATA_W  = 8 * MAX_BYTES;
  localparam int                  LP_CNT_W   = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [LP_CNT_W-1:0] LP_TO_LAST = LP_CNT_W'(TIMEOUT_CLKS - 2);
  localparam logic [8:0]          LP_MAX_LEN = 9'(MAX_BYTES);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_LEN, S_DATA, S_CSUM} state_t;

  state_t                r_State;
  state_t                w_NextState;
  logic [7:0]            r_Chk;
  logic [7:0]            r_Cmd;
  logic [7:0]            r_Len;
  logic [LP_DATA_W-1:0]  r_Data;
  logic [7:0]            r_Idx;
  logic [LP_CNT_W-1:0]   r_TimeCnt;
  logic                  r_Frame_Valid;
  logic [7:0]            r_Frame_Cmd;
  logic [7:0]            r_Frame_Len;
  logic [LP_DATA_W-1:0]  r_Frame_Data;
  logic                  r_Frame_Err;
  logic [1:0]            r_Err_Code;

  logic [7:0] w_ChkNext;
  logic       w_LenErr;
  logic       w_CsumErr;
  logic       w_Good;
  logic       w_Timeout;
  logic       w_Err;
  logic [1:0] w_ErrCode;

  function automatic logic [7:0] chkUpdate(input logic [7:0] c, input logic [7:0] b);
`ifdef UART_FRAME_CRC8_EN
    logic [7:0] x;
    x = c ^ b;
    for (int k = 0; k < 8; k++) begin
      x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    end
    return x;
`else
    return c ^ b;
`endif
  endfunction

  always_ff @(posedge i_Clock or negedge i_n_Reset) begin
    if (!i_n_Reset) begin
      r_State <= S_IDLE;
    end else begin
      r_State <= w_NextState;
    end
  end

  // A strobe on the timeout cycle wins, so the timeout term already excludes i_Rx_DV.
  always_comb begin
    w_NextState = r_State;
    if (w_Timeout) begin
      w_NextState = S_IDLE;
    end else if (io_Bus.i_Rx_DV) begin
      case (r_State)
        S_IDLE:  w_NextState = (io_Bus.i_Rx_Byte == SYNC_BYTE) ? S_CMD : S_IDLE;
        S_CMD:   w_NextState = S_LEN;
        S_LEN: begin
          if ({1'b0, io_Bus.i_Rx_Byte} > LP_MAX_LEN) begin
            w_NextState = S_IDLE;
          end else if (io_Bus.i_Rx_Byte == 8'd0) begin
            w_NextState = S_CSUM;
          end else begin
            w_NextState = S_DATA;
          end
        end
        S_DATA:  w_NextState = (r_Idx == r_Len - 8'd1) ? S_CSUM : S_DATA;
        S_CSUM:  w_NextState = S_IDLE;
        default: w_NextState = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_ChkNext = chkUpdate((r_State == S_CMD) ? 8'h00 : r_Chk, io_Bus.i_Rx_Byte);
    w_LenErr  = io_Bus.i_Rx_DV && (r_State == S_LEN) && ({1'b0, io_Bus.i_Rx_Byte} > LP_MAX_LEN);
    w_Good    = io_Bus.i_Rx_DV && (r_State == S_CSUM) && (io_Bus.i_Rx_Byte == r_Chk);
    w_CsumErr = io_Bus.i_Rx_DV && (r_State == S_CSUM) && (io_Bus.i_Rx_Byte != r_Chk);
    w_Timeout = !io_Bus.i_Rx_DV && (r_State != S_IDLE) && (r_TimeCnt == LP_TO_LAST);
    w_Err     = w_LenErr || w_CsumErr || w_Timeout;
    w_ErrCode = 2'd0;
    if (w_LenErr) begin
      w_ErrCode = 2'd1;
    end else if (w_CsumErr) begin
      w_ErrCode = 2'd2;
    end else if (w_Timeout) begin
      w_ErrCode = 2'd3;
    end
  end

  always_ff @(posedge i_Clock or negedge i_n_Reset) begin
    if (!i_n_Reset) begin
      r_Chk         <= '0;
      r_Cmd         <= '0;
      r_Len         <= '0;
      r_Data        <= '0;
      r_Idx         <= '0;
      r_TimeCnt     <= '0;
      r_Frame_Valid <= 1'b0;
      r_Frame_Cmd   <= '0;
      r_Frame_Len   <= '0;
      r_Frame_Data  <= '0;
      r_Frame_Err   <= 1'b0;
      r_Err_Code    <= '0;
    end else begin
      r_Frame_Valid <= w_Good;
      r_Frame_Err   <= w_Err;
      if (w_Err) begin
        r_Err_Code <= w_ErrCode;
      end
      if (w_Good) begin
        r_Frame_Cmd  <= r_Cmd;
        r_Frame_Len  <= r_Len;
        r_Frame_Data <= r_Data;
      end
      if (io_Bus.i_Rx_DV || w_Timeout || (r_State == S_IDLE)) begin
        r_TimeCnt <= '0;
      end else begin
        r_TimeCnt <= r_TimeCnt + 1'b1;
      end
      if (io_Bus.i_Rx_DV) begin
        case (r_State)
          S_CMD: begin
            r_Cmd <= io_Bus.i_Rx_Byte;
            r_Chk <= w_ChkNext;
          end
          S_LEN: begin
            r_Len  <= io_Bus.i_Rx_Byte;
            r_Chk  <= w_ChkNext;
            r_Data <= '0;
            r_Idx  <= '0;
          end
          S_DATA: begin
            for (int i = 0; i < MAX_BYTES; i++) begin
              if (r_Idx == 8'(i)) begin
                r_Data[8*i +: 8] <= io_Bus.i_Rx_Byte;
              end
            end
            r_Chk <= w_ChkNext;
            r_Idx <= r_Idx + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign io_Bus.o_Frame_Valid = r_Frame_Valid;
  assign io_Bus.o_Frame_Cmd   = r_Frame_Cmd;
  assign io_Bus.o_Frame_Len   = r_Frame_Len;
  assign io_Bus.o_Frame_Data  = r_Frame_Data;
  assign io_Bus.o_Frame_Err   = r_Frame_Err;
  assign io_Bus.o_Err_Code    = r_Err_Code;
  assign io_Bus.o_Busy        = (r_State != S_IDLE);

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Randomized self-checking bench for uart_frame_decoder; honours UART_FRAME_CRC8_EN.
module tb_uart_frame_decoder;

  localparam int         MAX_BYTES    = 16;
  localparam int         TIMEOUT_CLKS = 64;
  localparam logic [7:0] SYNC         = 8'hA5;

  logic clk  = 1'b0;
  logic rstN = 1'b0;

  int checkCount = 0;
  int errorCount = 0;
  int obsValid   = 0;
  int obsErr     = 0;
  int expValid   = 0;
  int expErr     = 0;

  logic [7:0]   expCmd     = '0;
  logic [7:0]   expLen     = '0;
  logic [127:0] expData    = '0;
  logic [1:0]   expErrCode = '0;
  logic [7:0]   pl[$];

  always #5 clk = ~clk;

  uart_frame_decoder_if #(.MAX_BYTES(MAX_BYTES)) bus ();

  uart_frame_decoder #(
    .MAX_BYTES   (MAX_BYTES),
    .SYNC_BYTE   (SYNC),
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) dut (
    .i_Clock  (clk),
    .i_n_Reset(rstN),
    .io_Bus   (bus)
  );

  always @(negedge clk) begin
    if (rstN) begin
      if (bus.o_Frame_Valid) obsValid++;
      if (bus.o_Frame_Err) obsErr++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Check value computed bit-serially over the whole message, MSB first.
  function automatic logic [7:0] modelCheck(input logic [7:0] body[$]);
    logic [7:0] acc;
    acc = 8'h00;
`ifdef UART_FRAME_CRC8_EN
    foreach (body[n]) begin
      for (int b = 7; b >= 0; b--) begin
        logic fb;
        fb  = acc[7] ^ body[n][b];
        acc = {acc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
`else
    foreach (body[n]) acc = acc ^ body[n];
`endif
    return acc;
  endfunction

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    bus.i_Rx_DV   = 1'b1;
    bus.i_Rx_Byte = b;
    @(negedge clk);
    bus.i_Rx_DV   = 1'b0;
  endtask

  task automatic checkHeld(input string tag);
    idleCycles(1);
    checkOutput({tag, ".cmd"},    bus.o_Frame_Cmd,  expCmd);
    checkOutput({tag, ".len"},    bus.o_Frame_Len,  expLen);
    checkOutput({tag, ".data"},   bus.o_Frame_Data, expData);
    checkOutput({tag, ".code"},   bus.o_Err_Code,   expErrCode);
    checkOutput({tag, ".busy"},   bus.o_Busy,       1'b0);
    checkOutput({tag, ".nvalid"}, obsValid,         expValid);
    checkOutput({tag, ".nerr"},   obsErr,           expErr);
  endtask

  task automatic sendFrame(input logic [7:0] cmd, input logic [7:0] payload[$], input logic [7:0] flip, input int maxGap);
    logic [7:0]   body[$];
    logic [7:0]   chk;
    logic [127:0] d;
    d = '0;
    body.push_back(cmd);
    body.push_back(8'(payload.size()));
    foreach (payload[n]) body.push_back(payload[n]);
    chk = modelCheck(body) ^ flip;
    applyStimulus(SYNC);
    foreach (body[n]) begin
      idleCycles($urandom_range(0, maxGap));
      applyStimulus(body[n]);
    end
    idleCycles($urandom_range(0, maxGap));
    applyStimulus(chk);
    if (flip != 8'h00) begin
      expErr++;
      expErrCode = 2'd2;
      checkOutput("csum.err",   bus.o_Frame_Err,   1'b1);
      checkOutput("csum.valid", bus.o_Frame_Valid, 1'b0);
      checkOutput("csum.code",  bus.o_Err_Code,    expErrCode);
      checkOutput("csum.hold",  bus.o_Frame_Cmd,   expCmd);
    end else begin
      for (int i = 0; i < payload.size(); i++) d[8*i +: 8] = payload[i];
      expValid++;
      expCmd  = cmd;
      expLen  = 8'(payload.size());
      expData = d;
      checkOutput("good.valid", bus.o_Frame_Valid, 1'b1);
      checkOutput("good.err",   bus.o_Frame_Err,   1'b0);
      checkOutput("good.data",  bus.o_Frame_Data,  expData);
    end
  endtask

  task automatic sendLenError(input logic [7:0] cmd, input logic [7:0] len);
    applyStimulus(SYNC);
    applyStimulus(cmd);
    applyStimulus(len);
    expErr++;
    expErrCode = 2'd1;
    checkOutput("len.err",   bus.o_Frame_Err,   1'b1);
    checkOutput("len.valid", bus.o_Frame_Valid, 1'b0);
    checkOutput("len.code",  bus.o_Err_Code,    expErrCode);
  endtask

  // stage 0: stop after SYNC, 1: after CMD, 2: after LEN plus 'sent' payload bytes.
  task automatic sendTimeout(input int stage, input logic [7:0] cmd, input logic [7:0] len, input int sent);
    int edges;
    edges = 0;
    applyStimulus(SYNC);
    if (stage >= 1) applyStimulus(cmd);
    if (stage >= 2) begin
      applyStimulus(len);
      for (int i = 0; i < sent; i++) applyStimulus(8'($urandom));
    end
    for (int k = 1; k <= TIMEOUT_CLKS + 8; k++) begin
      @(negedge clk);
      if (bus.o_Frame_Err) begin
        edges = k;
        break;
      end
    end
    expErr++;
    expErrCode = 2'd3;
    checkOutput("tmo.latency", edges,          TIMEOUT_CLKS - 1);
    checkOutput("tmo.code",    bus.o_Err_Code, expErrCode);
    checkOutput("tmo.busy",    bus.o_Busy,     1'b0);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] chk;
    int         len;
    bus.i_Rx_DV   = 1'b0;
    bus.i_Rx_Byte = 8'h00;
    idleCycles(2);
    checkOutput("rst.valid", bus.o_Frame_Valid, 1'b0);
    checkOutput("rst.err",   bus.o_Frame_Err,   1'b0);
    checkOutput("rst.busy",  bus.o_Busy,        1'b0);
    checkOutput("rst.data",  bus.o_Frame_Data,  '0);
    rstN = 1'b1;
    idleCycles(1);

    pl.delete(); pl.push_back(8'h11); pl.push_back(8'h22);
    sendFrame(8'h01, pl, 8'h00, 0);
    checkHeld("t1");

    pl.delete();
    sendFrame(8'h07, pl, 8'h00, 0);
    checkHeld("t2a");
    sendLenError(8'h01, 8'h11);
    checkHeld("t2b");

    pl.delete(); pl.push_back(8'h11); pl.push_back(8'h22);
    sendFrame(8'h01, pl, 8'h01, 0);
    pl.delete(); pl.push_back(8'h33); pl.push_back(8'h44); pl.push_back(8'h55);
    sendFrame(8'h09, pl, 8'h00, 0);
    checkHeld("t3");

    sendTimeout(2, 8'h01, 8'h02, 1);
    checkHeld("t4a");

    // Strobes landing exactly on the would-be timeout cycle keep the frame alive.
    pl.delete(); pl.push_back(8'h01); pl.push_back(8'h02); pl.push_back(8'h11); pl.push_back(8'h22);
    chk = modelCheck(pl);
    applyStimulus(SYNC);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h11);
    idleCycles(TIMEOUT_CLKS - 2);
    applyStimulus(8'h22);
    idleCycles(TIMEOUT_CLKS - 2);
    applyStimulus(chk);
    expValid++;
    expCmd  = 8'h01;
    expLen  = 8'h02;
    expData = 128'h2211;
    checkOutput("t4b.valid", bus.o_Frame_Valid, 1'b1);
    checkHeld("t4b");

    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'h5A);
    pl.delete(); pl.push_back(8'hA5);
    sendFrame(8'h03, pl, 8'h00, 0);
    checkHeld("t5");

    applyStimulus(SYNC);
    applyStimulus(8'h01);
    checkOutput("t6.busy", bus.o_Busy, 1'b1);
    rstN = 1'b0;
    #1;
    checkOutput("t6.valid", bus.o_Frame_Valid, 1'b0);
    checkOutput("t6.err",   bus.o_Frame_Err,   1'b0);
    checkOutput("t6.code",  bus.o_Err_Code,    2'd0);
    checkOutput("t6.cmd",   bus.o_Frame_Cmd,   8'd0);
    checkOutput("t6.len",   bus.o_Frame_Len,   8'd0);
    checkOutput("t6.data",  bus.o_Frame_Data,  '0);
    checkOutput("t6.busy0", bus.o_Busy,        1'b0);
    expCmd = '0; expLen = '0; expData = '0; expErrCode = '0;
    idleCycles(1);
    rstN = 1'b1;
    pl.delete(); pl.push_back(8'hDE); pl.push_back(8'hAD); pl.push_back(8'hBE);
    sendFrame(8'h02, pl, 8'h00, 0);
    checkHeld("t6");

    for (int iter = 0; iter < 40; iter++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        do b = 8'($urandom); while (b == SYNC);
        applyStimulus(b);
      end
      case ($urandom_range(0, 9))
        6: begin
          pl.delete();
          len = $urandom_range(1, MAX_BYTES);
          for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
          sendFrame(8'($urandom), pl, 8'(1 << $urandom_range(0, 7)), 3);
        end
        7: sendLenError(8'($urandom), 8'($urandom_range(MAX_BYTES + 1, 255)));
        8: begin
          len = $urandom_range(0, MAX_BYTES);
          sendTimeout($urandom_range(0, 2), 8'($urandom), 8'(len), $urandom_range(0, len));
        end
        9: begin
          pl.delete();
          sendFrame(8'($urandom), pl, 8'h00, 3);
        end
        default: begin
          pl.delete();
          len = $urandom_range(1, MAX_BYTES);
          for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
          sendFrame(8'($urandom), pl, 8'h00, 3);
        end
      endcase
      checkHeld("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
